// File: rtl/shift_exec_pkg.sv
// Shared constants, opcodes and pipeline payload types for the shift execution stage.
// The rotate opcode is enabled by defining SHIFT_EXEC_ROTATE_EN.
package shift_exec_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;

    localparam logic [1:0] OP_SLL = 2'b00;
    localparam logic [1:0] OP_SRL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    typedef struct packed {
        logic [WIDTH-1:0]   data;
        logic [SHAMT_W-1:0] shamt;
        logic [1:0]         op;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic             err;
    } s2_t;

    // Left shifts reuse the right-shift ladder on a bit-reversed word.
    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            r[i] = v[WIDTH-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/shift_exec_stage_core.sv
// Combinational shifter: a log2 ladder of fixed right shifts covering SLL, SRL, SRA and ROR.
// Op 11 is rotate-right when SHIFT_EXEC_ROTATE_EN is defined, otherwise an illegal opcode.
module shift_core
    import shift_exec_pkg::*;
(
    input  logic [WIDTH-1:0]   data,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         op,
    output logic [WIDTH-1:0]   result,
    output logic               err
);

    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    logic             illegal;
    logic             rot;
    logic             fill;
    logic [WIDTH-1:0] ladder;
    logic [WIDTH-1:0] wrap;

    always_comb begin
        illegal = 1'b0;
`ifdef SHIFT_EXEC_ROTATE_EN
        illegal = 1'b0;
`else
        illegal = (op == OP_ROR);
`endif
        rot    = (op == OP_ROR) && !illegal;
        fill   = (op == OP_SRA) && data[WIDTH-1];
        ladder = (op == OP_SLL) ? bit_rev(data) : data;
        wrap   = '0;

        // Each rung shifts by a power of two; the bits entering at the top are
        // the rotated-out bits, copies of the sign, or zeros.
        for (int k = 0; k < SHAMT_W; k++) begin
            if (shamt[k]) begin
                if (rot) begin
                    wrap = ladder << (WIDTH - (1 << k));
                end else if (fill) begin
                    wrap = ~(ALL_ONES >> (1 << k));
                end else begin
                    wrap = '0;
                end
                ladder = (ladder >> (1 << k)) | wrap;
            end
        end

        if (illegal) begin
            result = '0;
        end else if (op == OP_SLL) begin
            result = bit_rev(ladder);
        end else begin
            result = ladder;
        end
        err = illegal;
    end

endmodule

// File: rtl/shift_exec_stage.sv
// Two-stage pipelined shift unit with ready/valid on both sides and full backpressure.
// Op 11 rotates right when SHIFT_EXEC_ROTATE_EN is defined; otherwise it completes with out_err set.
module shift_exec_stage
    import shift_exec_pkg::*;
(
    input  logic               clock,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic [1:0]         in_op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic               out_zero,
    output logic               out_err
);

    // Handshake: a beat moves on a rising edge when valid && ready; ready never
    // looks at valid, and a stalled output keeps its payload unchanged.
    s1_t              s1_q;
    logic             s1_valid;
    s2_t              s2_q;
    logic             s2_valid;
    logic [31:0]      op_count;

    logic             adv1;
    logic             in_xfer;
    logic             out_xfer;
    logic [WIDTH-1:0] core_result;
    logic             core_err;

    assign adv1     = s1_valid && (!s2_valid || out_ready);
    assign in_ready = !s1_valid || adv1;
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = s2_valid && out_ready;

    shift_core u_core (
        .data   (s1_q.data),
        .shamt  (s1_q.shamt),
        .op     (s1_q.op),
        .result (core_result),
        .err    (core_err)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_xfer) begin
            s1_valid     <= 1'b1;
            s1_q.data    <= in_data;
            s1_q.shamt   <= in_shamt;
            s1_q.op      <= in_op;
        end else if (adv1) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else if (adv1) begin
            s2_valid     <= 1'b1;
            s2_q.result  <= core_result;
            s2_q.err     <= core_err;
        end else if (out_xfer) begin
            s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_count <= '0;
        end else if (out_xfer) begin
            op_count <= op_count + 32'd1;
        end
    end

    // The zero flag is qualified by valid so that it reads 0 out of reset.
    assign out_valid  = s2_valid;
    assign out_result = s2_q.result;
    assign out_err    = s2_q.err;
    assign out_zero   = s2_valid && !s2_q.err && (s2_q.result == '0);

endmodule

// File: tb/tb_shift_exec_stage.sv
// Self-checking bench for shift_exec_stage: directed vectors with literal expectations plus
// a per-cycle model compare. Build with SHIFT_EXEC_ROTATE_EN to exercise the rotate opcode.
module tb_shift_exec_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic [4:0]  in_shamt = '0;
    logic [1:0]  in_op = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_err;

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [33:0] exp_q[$];
    logic [31:0] exp_count = '0;
    logic        prev_hold = 1'b0;
    logic [33:0] prev_out = '0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    shift_exec_stage dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_err    (out_err)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Expected {err, zero, result} straight from the shift definitions.
    function automatic logic [33:0] model(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o);
        logic [31:0] r;
        logic        e;
        r = '0;
        e = 1'b0;
        case (o)
            2'b00: r = d << s;
            2'b01: r = d >> s;
            2'b10: r = $unsigned($signed(d) >>> s);
            default: begin
`ifdef SHIFT_EXEC_ROTATE_EN
                r = (s == 5'd0) ? d : ((d >> s) | (d << (32 - int'(s))));
`else
                e = 1'b1;
`endif
            end
        endcase
        return {e, (r == 32'd0) && !e, r};
    endfunction

    // Per-cycle compare against the model queue.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
            exp_count = '0;
            prev_hold = 1'b0;
            check("reset_out_valid", 64'(out_valid), 64'(0));
            check("reset_out_word", 64'({out_err, out_zero, out_result}), 64'(0));
            check("reset_in_ready", 64'(in_ready), 64'(1));
        end else begin
            check("in_ready", 64'(in_ready), 64'(!(exp_q.size() == 2 && !out_ready)));
            check("op_count", 64'(dut.op_count), 64'(exp_count));
            if (prev_hold) begin
                check("hold_valid", 64'(out_valid), 64'(1));
                check("hold_word", 64'({out_err, out_zero, out_result}), 64'(prev_out));
            end
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", 64'(out_valid), 64'(0));
                end else begin
                    check("out_word", 64'({out_err, out_zero, out_result}), 64'(exp_q[0]));
                end
            end
            prev_hold = out_valid && !out_ready;
            prev_out  = {out_err, out_zero, out_result};
            if (out_valid && out_ready) begin
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                exp_count = exp_count + 32'd1;
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_data, in_shamt, in_op));
        end
    end

    // Called just after a rising edge; returns just after the edge that took the op.
    task automatic send(input logic [31:0] d, input logic [4:0] s, input logic [1:0] o);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_shamt = s;
        in_op    = o;
        @(negedge clock);
        while (!in_ready && waited < 50) begin
            waited++;
            @(negedge clock);
        end
        if (!in_ready) check("send_accept", 64'(in_ready), 64'(1));
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic run_one(input string name, input logic [31:0] d, input logic [4:0] s,
                           input logic [1:0] o, input logic e, input logic z, input logic [31:0] r);
        int lat;
        out_ready = 1'b1;
        send(d, s, o);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!out_valid && lat < 10);
        check({name, "_latency"}, 64'(lat), 64'(2));
        check(name, 64'({out_err, out_zero, out_result}), 64'({e, z, r}));
        @(posedge clock);
        #1;
    endtask

    task automatic wait_drain();
        int budget;
        budget = 0;
        while ((exp_q.size() != 0 || out_valid) && budget < 40) begin
            @(negedge clock);
            budget++;
        end
        check("drain", 64'(exp_q.size()), 64'(0));
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bp_data [4];
        logic [31:0] st_data [8];
        logic [4:0]  st_shamt[8];
        logic [1:0]  st_op   [8];
        logic [31:0] cnt0;
        int          accepts;
        int          budget;
        int          start;

        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;

        // Directed vectors with hand-computed results {err, zero, result}.
        run_one("srl_basic",   32'h0000_0001, 5'd1,  2'b01, 1'b0, 1'b1, 32'h0000_0000);
        run_one("sra_fill",    32'h8000_0000, 5'd31, 2'b10, 1'b0, 1'b0, 32'hFFFF_FFFF);
        run_one("sll_31",      32'h0000_0001, 5'd31, 2'b00, 1'b0, 1'b0, 32'h8000_0000);
        run_one("sll_0",       32'h0000_0001, 5'd0,  2'b00, 1'b0, 1'b0, 32'h0000_0001);
        run_one("srl_31",      32'h8000_0000, 5'd31, 2'b01, 1'b0, 1'b0, 32'h0000_0001);
        run_one("sra_0",       32'h8000_0001, 5'd0,  2'b10, 1'b0, 1'b0, 32'h8000_0001);
        run_one("sra_4",       32'hF000_0000, 5'd4,  2'b10, 1'b0, 1'b0, 32'hFF00_0000);
        run_one("srl_8",       32'hDEAD_BEEF, 5'd8,  2'b01, 1'b0, 1'b0, 32'h00DE_ADBE);
        run_one("sll_12",      32'h1234_5678, 5'd12, 2'b00, 1'b0, 1'b0, 32'h4567_8000);
        run_one("sra_pos",     32'h7FFF_FFFF, 5'd30, 2'b10, 1'b0, 1'b0, 32'h0000_0001);
`ifdef SHIFT_EXEC_ROTATE_EN
        run_one("op11_ror",    32'h0000_0003, 5'd1,  2'b11, 1'b0, 1'b0, 32'h8000_0001);
        run_one("op11_ror_0",  32'hA5A5_0000, 5'd0,  2'b11, 1'b0, 1'b0, 32'hA5A5_0000);
`else
        run_one("op11_err",    32'h0000_0003, 5'd1,  2'b11, 1'b1, 1'b0, 32'h0000_0000);
        run_one("op11_err_0",  32'h0000_0000, 5'd0,  2'b11, 1'b1, 1'b0, 32'h0000_0000);
`endif

        // Back-to-back stream at full rate.
        st_data  = '{32'h0000_00FF, 32'h8000_0000, 32'hCAFE_F00D, 32'h0000_0000,
                     32'hFFFF_FFFF, 32'h0F0F_0F0F, 32'h0000_0010, 32'h8765_4321};
        st_shamt = '{5'd4, 5'd1, 5'd16, 5'd7, 5'd31, 5'd3, 5'd5, 5'd20};
        st_op    = '{2'b00, 2'b10, 2'b01, 2'b00, 2'b00, 2'b11, 2'b01, 2'b10};
        out_ready = 1'b1;
        start = cyc;
        for (int i = 0; i < 8; i++) send(st_data[i], st_shamt[i], st_op[i]);
        check("stream_cycles", 64'(cyc - start), 64'(8));
        wait_drain();

        // Backpressure: only two ops fit while the output is blocked.
        bp_data = '{32'h0000_0011, 32'h0000_0022, 32'h0000_0033, 32'h0000_0044};
        cnt0 = dut.op_count;
        out_ready = 1'b0;
        accepts = 0;
        for (int c = 0; c < 6; c++) begin
            in_valid = 1'b1;
            in_data  = bp_data[accepts];
            in_shamt = 5'd1;
            in_op    = 2'b00;
            @(negedge clock);
            if (in_ready) accepts++;
            @(posedge clock);
            #1;
        end
        check("bp_accepts", 64'(accepts), 64'(2));
        check("bp_in_ready", 64'(in_ready), 64'(0));
        check("bp_held_result", 64'(out_result), 64'(32'h0000_0022));
        out_ready = 1'b1;
        budget = 0;
        while (accepts < 4 && budget < 20) begin
            in_valid = 1'b1;
            in_data  = bp_data[accepts];
            @(negedge clock);
            if (in_ready) accepts++;
            @(posedge clock);
            #1;
            budget++;
        end
        in_valid = 1'b0;
        check("bp_all_accepted", 64'(accepts), 64'(4));
        wait_drain();
        check("bp_count", 64'(dut.op_count - cnt0), 64'(4));

        // Asynchronous reset with two ops in flight.
        out_ready = 1'b0;
        send(32'h0000_0100, 5'd2, 2'b01);
        send(32'h0000_0200, 5'd3, 2'b00);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_out_valid", 64'(out_valid), 64'(0));
        check("rst_async_count", 64'(dut.op_count), 64'(0));
        check("rst_async_in_ready", 64'(in_ready), 64'(1));
        @(posedge clock);
        #1;
        reset = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("post_reset_idle", 64'(out_valid), 64'(0));
        end
        check("post_reset_count", 64'(dut.op_count), 64'(0));

        @(posedge clock);
        #1;
        run_one("after_reset", 32'h0000_0004, 5'd2, 2'b01, 1'b0, 1'b0, 32'h0000_0001);
        check("final_count", 64'(dut.op_count), 64'(1));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
